// File: rtl/fpu_arbiter_pkg.sv
// Shared FPU types: operation codes, ZCNV flag bit positions and the arbiter state encoding.
package fpu_arbiter_pkg;

    typedef enum logic {
        FPU_ADD = 1'b0,
        FPU_SUB = 1'b1
    } fpuOp_t;

    localparam int CC_Z = 3;
    localparam int CC_C = 2;
    localparam int CC_N = 1;
    localparam int CC_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } fpuArbState_t;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Request/response bundle between the issue logic (master) and the FPU arbiter (slave).
interface fpu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int BW      = 16
);
    import fpu_arbiter_pkg::*;

    logic [NUM_REQ-1:0]         reqValid;
    logic [NUM_REQ-1:0]         reqReady;
    logic [NUM_REQ-1:0][BW-1:0] reqIn1;
    logic [NUM_REQ-1:0][BW-1:0] reqIn2;
    fpuOp_t [NUM_REQ-1:0]       reqOp;
    logic [NUM_REQ-1:0]         rspValid;
    logic [NUM_REQ-1:0]         rspReady;
    logic [BW-1:0]              rspOut;
    logic [3:0]                 rspCondCodes;

    modport master (
        output reqValid, reqIn1, reqIn2, reqOp, rspReady,
        input  reqReady, rspValid, rspOut, rspCondCodes
    );

    modport slave (
        input  reqValid, reqIn1, reqIn2, reqOp, rspReady,
        output reqReady, rspValid, rspOut, rspCondCodes
    );

endinterface

// File: rtl/fpu.sv
// Combinational floating-point add/sub (denormals flushed, truncating), with ZCNV flags.
module FPU
    import fpu_arbiter_pkg::*;
#(
    parameter int BW = 16,
    parameter int EW = 5,
    parameter int SW = 10
) (
    input  logic [BW-1:0] in1,
    input  logic [BW-1:0] in2,
    input  fpuOp_t        op,
    output logic [BW-1:0] fpuOut,
    output logic [3:0]    condCodes
);
    localparam int W    = SW + 4;
    localparam int EMAX = (1 << EW) - 1;

    logic          sA, sB, sL, lost, ovf, swap;
    logic [EW-1:0] eA, eB, eL, eS;
    logic [W-1:0]  mA, mB, mL, mS, mSh, mR;
    logic [W:0]    sum;
    int            d, eR;

    always_comb begin
        sA   = in1[BW-1];
        sB   = in2[BW-1] ^ (op == FPU_SUB);
        eA   = in1[BW-2 -: EW];
        eB   = in2[BW-2 -: EW];
        mA   = (eA == '0) ? '0 : {1'b1, in1[SW-1:0], 3'b000};
        mB   = (eB == '0) ? '0 : {1'b1, in2[SW-1:0], 3'b000};
        swap = {eB, mB} > {eA, mA};
        sL   = swap ? sB : sA;
        eL   = swap ? eB : eA;
        eS   = swap ? eA : eB;
        mL   = swap ? mB : mA;
        mS   = swap ? mA : mB;
        d    = int'(eL) - int'(eS);
        if (d >= W) begin
            mSh  = '0;
            lost = |mS;
        end else begin
            mSh  = mS >> d;
            lost = |(mS & ~({W{1'b1}} << d));
        end
        eR  = int'(eL);
        sum = '0;
        if (sA == sB) begin
            sum = {1'b0, mL} + {1'b0, mSh};
            if (sum[W]) begin
                mR   = sum[W:1];
                lost = lost | sum[0];
                eR   = eR + 1;
            end else begin
                mR = sum[W-1:0];
            end
        end else begin
            mR = mL - mSh;
            for (int i = 0; i < W; i++) begin
                if (mR != '0 && !mR[W-1]) begin
                    mR = mR << 1;
                    eR = eR - 1;
                end
            end
        end
        ovf = 1'b0;
        if (mR == '0 || eR <= 0) begin
            fpuOut = '0;
        end else if (eR >= EMAX) begin
            fpuOut = {sL, EW'(EMAX), SW'(0)};
            ovf    = 1'b1;
        end else begin
            fpuOut = {sL, eR[EW-1:0], mR[W-2:3]};
        end
        condCodes       = '0;
        condCodes[CC_Z] = (fpuOut[BW-2:0] == '0);
        condCodes[CC_C] = lost | (|mR[2:0]) | ovf;
        condCodes[CC_N] = fpuOut[BW-1];
        condCodes[CC_V] = ovf;
    end

endmodule

// File: rtl/fpu_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rrPtr, wrapping.
module fpu_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] reqValid,
    input  logic [IDW-1:0]     rrPtr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grantId
);
    int   idx;
    logic found;

    always_comb begin
        grantId = '0;
        found   = 1'b0;
        idx     = 0;
        // Scan farthest-first so the requester closest to rrPtr wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rrPtr) + k) % NUM_REQ;
            if (reqValid[idx]) begin
                grantId = IDW'(idx);
                found   = 1'b1;
            end
        end
        grant = found ? (NUM_REQ'(1) << grantId) : '0;
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one FPU among NUM_REQ requesters; define FPU_ARB_STATS_EN
// to add saturating completed-op / overflow counters.
module fpu_arbiter
    import fpu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BW      = 16,
    parameter int EW      = 5,
    parameter int SW      = 10
) (
    input  logic          clock,
    input  logic          reset,
    fpu_arbiter_if.slave  bus
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [15:0]   statOps,
    output logic [15:0]   statOvf
`endif
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    fpuArbState_t       state, nextState;
    logic [IDW-1:0]     rrPtr, grantId, pickId;
    logic [NUM_REQ-1:0] pickGrant;
    logic [BW-1:0]      in1Q, in2Q, fpuOut;
    fpuOp_t             opQ;
    logic [3:0]         condCodes;
    logic               load, done;

    fpu_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) uPick (
        .reqValid (bus.reqValid),
        .rrPtr    (rrPtr),
        .grant    (pickGrant),
        .grantId  (pickId)
    );

    FPU #(.BW(BW), .EW(EW), .SW(SW)) uFpu (
        .in1       (in1Q),
        .in2       (in2Q),
        .op        (opQ),
        .fpuOut    (fpuOut),
        .condCodes (condCodes)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Handshakes are suppressed while reset is high so nothing is accepted only to be dropped.
    always_comb begin
        nextState    = state;
        bus.reqReady = '0;
        bus.rspValid = '0;
        load         = 1'b0;
        done         = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: if (|bus.reqValid) begin
                    bus.reqReady = pickGrant;
                    load         = 1'b1;
                    nextState    = EXEC;
                end
                EXEC: nextState = RESP;
                RESP: begin
                    bus.rspValid[grantId] = 1'b1;
                    if (bus.rspReady[grantId]) begin
                        done      = 1'b1;
                        nextState = IDLE;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr   <= '0;
            grantId <= '0;
        end else begin
            if (load) grantId <= pickId;
            if (done) rrPtr <= (grantId == IDW'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (load) begin
            in1Q <= bus.reqIn1[pickId];
            in2Q <= bus.reqIn2[pickId];
            opQ  <= bus.reqOp[pickId];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.rspOut       <= '0;
            bus.rspCondCodes <= '0;
        end else if (state == EXEC) begin
            bus.rspOut       <= fpuOut;
            bus.rspCondCodes <= condCodes;
        end
    end

`ifdef FPU_ARB_STATS_EN
    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            statOps <= '0;
            statOvf <= '0;
        end else if (done) begin
            statOps <= satInc(statOps);
            if (bus.rspCondCodes[CC_V]) statOvf <= satInc(statOvf);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed + randomized bench for fpu_arbiter with a pending-set round-robin model.
module tb_fpu_arbiter;
    import fpu_arbiter_pkg::*;

    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fpu_arbiter_if #(.NUM_REQ(N), .BW(16)) bus();

`ifdef FPU_ARB_STATS_EN
    logic [15:0] statOps, statOvf;
`endif

    fpu_arbiter #(.NUM_REQ(N), .BW(16), .EW(5), .SW(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef FPU_ARB_STATS_EN
        ,
        .statOps (statOps),
        .statOvf (statOvf)
`endif
    );

    int          errors = 0;
    int          checks = 0;
    int          ptr = 0;
    int          opsDone = 0;
    int          ovfDone = 0;
    bit          pend[N];
    logic [15:0] expOut[N];
    logic [3:0]  expCc[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Half-precision encoding of a small integer.
    function automatic logic [15:0] enc(input int r);
        logic [15:0] h;
        int m, p;
        if (r == 0) return 16'h0000;
        m = (r < 0) ? -r : r;
        p = 0;
        for (int k = 0; k < 16; k++) if (m >= (1 << k)) p = k;
        h[15]    = (r < 0);
        h[14:10] = 5'(15 + p);
        h[9:0]   = 10'((m << (10 - p)) & 'h3FF);
        return h;
    endfunction

    task automatic post(input int id, input logic [15:0] a, input logic [15:0] b, input fpuOp_t op,
                        input logic [15:0] eo, input logic [3:0] ec);
        bus.reqIn1[id]   = a;
        bus.reqIn2[id]   = b;
        bus.reqOp[id]    = op;
        bus.reqValid[id] = 1'b1;
        expOut[id]       = eo;
        expCc[id]        = ec;
        pend[id]         = 1'b1;
    endtask

    task automatic postInt(input int id);
        int a, b, r;
        fpuOp_t op;
        a  = int'($urandom_range(0, 15));
        b  = int'($urandom_range(0, 15));
        op = fpuOp_t'($urandom_range(0, 1));
        r  = (op == FPU_ADD) ? a + b : a - b;
        post(id, enc(a), enc(b), op, enc(r), {r == 0, 1'b0, r < 0, 1'b0});
    endtask

    function automatic int nextId();
        for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    task automatic doReset();
        reset        = 1'b1;
        bus.reqValid = '0;
        bus.rspReady = '1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        ptr     = 0;
        opsDone = 0;
        ovfDone = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
    endtask

    // Called at a negedge in IDLE with rspReady high; serves the model's next requester.
    task automatic serve(input logic [3:0] ccMask);
        int id, waitCnt;
        id = nextId();
        waitCnt = 0;
        #1;
        while (bus.reqReady == '0 && waitCnt < 20) begin
            @(negedge clock);
            #1;
            waitCnt++;
        end
        chk("reqReady", 32'(bus.reqReady), 32'(1) << id);
        @(posedge clock);
        #1 bus.reqValid[id] = 1'b0;
        pend[id] = 1'b0;
        @(negedge clock);
        chk("execQuiet", {bus.reqReady, bus.rspValid}, 32'd0);
        @(negedge clock);
        chk("rspValid", 32'(bus.rspValid), 32'(1) << id);
        chk("rspOut", 32'(bus.rspOut), 32'(expOut[id]));
        chk("rspCc", 32'(bus.rspCondCodes & ccMask), 32'(expCc[id] & ccMask));
        ptr = (id + 1) % N;
        opsDone++;
        if (expCc[id][CC_V]) ovfDone++;
        @(negedge clock);
    endtask

    initial begin
        logic [15:0] held;
        bus.reqValid = '0;
        bus.reqIn1   = '0;
        bus.reqIn2   = '0;
        bus.reqOp    = '0;
        bus.rspReady = '1;

        doReset();
        chk("rstReqReady", 32'(bus.reqReady), 32'd0);
        chk("rstRspValid", 32'(bus.rspValid), 32'd0);
        chk("rstRspOut", 32'(bus.rspOut), 32'd0);
        chk("rstCc", 32'(bus.rspCondCodes), 32'd0);

        post(0, 16'h3C00, 16'h3C00, FPU_ADD, 16'h4000, 4'b0000);
        serve(4'hF);
        post(1, 16'h3C00, 16'h3C00, FPU_SUB, 16'h0000, 4'b1000);
        serve(4'hF);
        post(2, 16'h3C00, 16'h0000, FPU_SUB, 16'h3C00, 4'b0000);
        serve(4'hF);

        // All four at once from reset: grants 0,1,2,3.
        doReset();
        for (int i = 0; i < N; i++) postInt(i);
        for (int i = 0; i < N; i++) serve(4'hF);

        post(3, 16'h7BFF, 16'h7BFF, FPU_ADD, 16'h7C00, 4'b0001);
        serve(4'b0001);
`ifdef FPU_ARB_STATS_EN
        chk("statOps", 32'(statOps), 32'(opsDone));
        chk("statOvf", 32'(statOvf), 32'(ovfDone));
`endif

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 1) == 1) postInt(i);
            if (!(pend[0] || pend[1] || pend[2] || pend[3])) postInt(int'($urandom_range(0, N - 1)));
            serve(4'hF);
        end
        while (pend[0] || pend[1] || pend[2] || pend[3]) serve(4'hF);

        // Backpressure: response held, other requesters wait, others' rspReady ignored.
        doReset();
        bus.rspReady = '0;
        post(1, enc(3), enc(4), FPU_ADD, enc(7), 4'b0000);
        #1 chk("bpGrant", 32'(bus.reqReady), 32'h2);
        @(posedge clock);
        #1 bus.reqValid[1] = 1'b0;
        pend[1] = 1'b0;
        post(0, enc(9), enc(2), FPU_SUB, enc(7), 4'b0000);
        post(2, enc(5), enc(6), FPU_SUB, enc(-1), 4'b0010);
        bus.rspReady = 4'b1101;
        @(negedge clock);
        @(negedge clock);
        held = bus.rspOut;
        chk("bpOut", 32'(held), 32'(enc(7)));
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("bpValid", 32'(bus.rspValid), 32'h2);
            chk("bpStable", 32'(bus.rspOut), 32'(held));
            chk("bpReqReady", 32'(bus.reqReady), 32'd0);
        end
        bus.rspReady = '1;
        ptr = 2;
        opsDone++;
        @(negedge clock);
        serve(4'hF);
        serve(4'hF);
`ifdef FPU_ARB_STATS_EN
        chk("statOpsBp", 32'(statOps), 32'(opsDone));
`endif

        // Reset during EXEC drops the op and restarts round-robin at requester 0.
        doReset();
        post(2, enc(1), enc(1), FPU_ADD, enc(2), 4'b0000);
        #1 chk("rstExGrant", 32'(bus.reqReady), 32'h4);
        @(posedge clock);
        #1 bus.reqValid[2] = 1'b0;
        pend[2] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        ptr     = 0;
        opsDone = 0;
        ovfDone = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("rstExNoRsp", 32'(bus.rspValid), 32'd0);
        end
        post(3, enc(4), enc(4), FPU_ADD, enc(8), 4'b0000);
        post(0, enc(6), enc(2), FPU_SUB, enc(4), 4'b0000);
        serve(4'hF);
        serve(4'hF);
`ifdef FPU_ARB_STATS_EN
        chk("statOpsEnd", 32'(statOps), 32'(opsDone));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares a single combinational FPU instance between `NUM_REQ` requesters. Each requester issues `{in1, in2, op}` over a valid/ready handshake, and a round-robin arbiter grants one request at a time. The block registers the operands, drives the FPU, captures `fpuOut`/`condCodes` and returns them to the granted requester over a per-requester valid/ready response. It sits between the issue logic and the FPU datapath.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..8
- `BW`, 16 — operand/result width
- `EW`, 5 — exponent width, passed to FPU
- `SW`, 10 — significand width, passed to FPU

Ports:
- `clock`  in  1  — single clock, all state on rising edge
- `reset`  in  1  — synchronous, active-high
- `reqValid`  in  `NUM_REQ`  — request pending, per requester
- `reqReady`  out  `NUM_REQ`  — request accepted this cycle (one-hot or zero)
- `reqIn1`  in  `NUM_REQ`×`BW`  — operand 1, per requester
- `reqIn2`  in  `NUM_REQ`×`BW`  — operand 2, per requester
- `reqOp`  in  `NUM_REQ`×`fpuOp_t`  — operation, per requester
- `rspValid`  out  `NUM_REQ`  — result available for requester i (one-hot or zero)
- `rspReady`  in  `NUM_REQ`  — requester i takes result
- `rspOut`  out  `BW`  — shared result bus
- `rspCondCodes`  out  4  — ZCNV flags: [3]=Z, [2]=C, [1]=N, [0]=V

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If any `reqValid` is set, pick the first set bit starting at `rrPtr` and wrapping modulo `NUM_REQ`.
  - Assert `reqReady[g]` combinationally in that cycle.
  - Latch `reqIn1[g]`, `reqIn2[g]`, `reqOp[g]` and `grantId=g`, then go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC:**
  - Latched operands and op drive the FPU.
  - Capture `fpuOut` into `rspOut` and `condCodes` into `rspCondCodes`, then go to RESP.
- **RESP:**
  - `rspValid[grantId]=1`. `rspOut` and `rspCondCodes` are held stable.
  - On `rspReady[grantId]`: set `rrPtr = (grantId+1) mod NUM_REQ` and go to IDLE.
  - `rspReady` bits of other requesters are ignored.
- `reqReady` is 0 in EXEC and RESP. Requests stay pending and are not dropped.
- A requester keeps `reqValid` asserted until it sees `reqReady`. A request whose `reqValid` drops before grant is not served.
- No arithmetic is done in this block. Results are exactly the FPU outputs for the latched operands.

## Timing
- Reset values:
  - State IDLE, `rrPtr=0`.
  - `reqReady=0`, `rspValid=0`, `rspOut=0`, `rspCondCodes=0`.
- Latency: accept at edge T (IDLE), capture at edge T+1, `rspValid` high during cycle T+2.
- Minimum 3 cycles per operation when `rspReady` is already high. A new accept can occur in the cycle after the response handshake.
- Simultaneous requests: strict round-robin from `rrPtr`. No requester waits more than `NUM_REQ-1` grants.
- Backpressure: RESP holds indefinitely and no new grant is issued.
- Reset asserted in any state:
  - The next edge forces IDLE and discards any in-flight op. No `rspValid` is issued for it.
  - `rrPtr` returns to 0.
- `reqReady` and `reqValid` of the granted requester in the same cycle form the transfer. No combinational path from `rspReady` to `reqReady`.

## Configuration
- `FPU_ARB_STATS_EN` defined:
  - Adds output `statOps[15:0]`: count of completed response handshakes.
  - Adds output `statOvf[15:0]`: count of completed responses with V=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Not defined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package (`constants.sv`) holds:
  - `fpuOp_t` (FPU_ADD, FPU_SUB, …) and the ZCNV bit-index constants.
  - New `fpuArbState_t` {IDLE, EXEC, RESP}.
- Sub-module `fpu_rr_pick`: combinational round-robin picker. Inputs `reqValid`, `rrPtr`; outputs one-hot `grant` and `grantId`.
- The existing `FPU` is instantiated once inside `fpu_arbiter`.

## Test plan
- After reset, check outputs only → `reqReady=0`, `rspValid=0`, `rspOut=0`, `rspCondCodes=0`.
- Req0: 16'h3C00 + 16'h3C00 FPU_ADD with `rspReady` high → `reqReady[0]` at T, `rspValid[0]` at T+2, `rspOut=16'h4000`.
- Req1: 16'h3C00 FPU_SUB 16'h3C00 → `rspOut=16'h0000`, `rspCondCodes[3]` (Z)=1.
- Req2: 16'h3C00 FPU_SUB 16'h0000 → `rspOut=16'h3C00`, Z=0.
- All four requesters valid in the same cycle from reset → grants in order 0,1,2,3. Each `rspValid` is one-hot to the matching requester.
- `rspReady` held low 5 cycles in RESP → `rspValid` and `rspOut` stable, `reqReady` stays 0. Release → IDLE, next grant goes to `grantId+1`.
- `reset` pulsed during EXEC → IDLE next edge, no `rspValid`, next grant starts at requester 0.
- With `FPU_ARB_STATS_EN`: 3 ops, one of them 16'h7BFF + 16'h7BFF giving V=1 → `statOps=3`, `statOvf=1`.
